// File: rtl/window_sum_ctrl.sv
// Five-tap window-sum controller. It gates sample acceptance into an external shift register and
// emits a decimated, full-precision signed sum of the taps through a valid/ready output.
module window_sum_ctrl #(
    parameter int IN_W  = 37,
    parameter int DEPTH = 5,
    parameter int DECIM = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    output logic                   sr_en,
    output logic                   sr_data_ready,
    output logic                   sr_rst,
    input  logic signed [IN_W-1:0] tap1,
    input  logic signed [IN_W-1:0] tap2,
    input  logic signed [IN_W-1:0] tap3,
    input  logic signed [IN_W-1:0] tap4,
    input  logic signed [IN_W-1:0] tap5,
    output logic signed [IN_W+2:0] sum_out,
    output logic                   sum_valid,
    input  logic                   sum_ready
);

    localparam int SW = IN_W + 3;

    typedef enum logic [1:0] {RUN, CAP, ADD} state_t;

    state_t               state;
    logic [2:0]           fill_cnt;
    logic [3:0]           phase_cnt;
    logic signed [SW-1:0] p0, p1, p2;
    logic                 filled, trig_next, hold, accept, trigger;

    assign filled    = (fill_cnt == 3'(DEPTH));
    assign trig_next = filled ? (phase_cnt == 4'(DECIM - 1)) : (fill_cnt == 3'(DEPTH - 1));

    // A trigger is refused while a sum is pending or is being registered, so no sum is lost.
    assign hold      = (sum_valid && !sum_ready) || (state == ADD);
    assign acc_ready = !rst && !flush && (state != CAP) && !(trig_next && hold);
    assign accept    = acc_valid && acc_ready;
    assign trigger   = accept && trig_next;

    assign sr_data_ready = accept;
    assign sr_en         = ~accept;
    assign sr_rst        = rst | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fill_cnt  <= '0;
            phase_cnt <= '0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else if (flush) begin
            // Leaving CAP/ADD drops any partials in flight; sum_out keeps its last value.
            state     <= RUN;
            fill_cnt  <= '0;
            phase_cnt <= '0;
            sum_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (!filled)
                    fill_cnt <= fill_cnt + 3'd1;
                else
                    phase_cnt <= trigger ? 4'd0 : phase_cnt + 4'd1;
            end

            case (state)
                RUN: if (trigger) state <= CAP;
                CAP: begin
                    // The taps have taken the triggering sample by now.
                    p0    <= SW'(tap1) + SW'(tap2);
                    p1    <= SW'(tap3) + SW'(tap4);
                    p2    <= SW'(tap5);
                    state <= ADD;
                end
                ADD: begin
                    sum_out <= p0 + p1 + p2;
                    state   <= RUN;
                end
                default: state <= RUN;
            endcase

            if (state == ADD)
                sum_valid <= 1'b1;
            else if (sum_valid && sum_ready)
                sum_valid <= 1'b0;
        end
    end

endmodule

// File: doc/window_sum_ctrl.md
WINDOW_SUM_CTRL -- requirements
Module: window_sum_ctrl

Interface
REQ-001 Parameter: IN_W, 37, signed tap and sample width.
REQ-002 Parameter: DEPTH, 5, window length; fixed at 5, any other value is unsupported.
REQ-003 Parameter: DECIM, 5, new samples per emitted window sum after the first window; legal range 1..15.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 flush  in  1  synchronous restart pulse; lower priority than rst.
REQ-007 acc_valid  in  1  accumulator unit has a sample.
REQ-008 acc_ready  out  1  controller accepts the sample this cycle; accept = acc_valid && acc_ready.
REQ-009 sr_en  out  1  active-low hold/enable to the output shift register.
REQ-010 sr_data_ready  out  1  shift strobe to the shift register.
REQ-011 sr_rst  out  1  shift-register reset, active-high.
REQ-012 tap1..tap5  in  IN_W each  signed shift-register stages, newest first.
REQ-013 sum_out  out  IN_W+3  signed window sum.
REQ-014 sum_valid  out  1  sum_out valid; held until consumed.
REQ-015 sum_ready  in  1  downstream consumes; consume = sum_valid && sum_ready.

Function
REQ-016 Shift control is combinational: sr_data_ready = accept; sr_en = ~accept.
REQ-017 sr_rst = rst | flush, combinational.
REQ-018 fill_cnt (3 bits) increments on accept and saturates at DEPTH.
REQ-019 phase_cnt (4 bits) increments on accept once fill_cnt = DEPTH, and wraps to 0 on a trigger.
REQ-020 Trigger: the accept that makes fill_cnt reach DEPTH (first window), or later the accept that makes phase_cnt reach DECIM.
REQ-021 FSM states: RUN, CAP, ADD. Reset state is RUN.
REQ-022 RUN -> CAP on a trigger; CAP -> ADD unconditionally; ADD -> RUN unconditionally.
REQ-023 CAP (trigger+1): tap values are settled; register partials p0 = tap1+tap2, p1 = tap3+tap4, p2 = tap5, each sign-extended to IN_W+3.
REQ-024 ADD (trigger+2): register sum_out = p0+p1+p2; sum_valid rises at trigger+3.
REQ-025 Latency is 3 cycles from the triggering accept to sum_valid=1.
REQ-026 Arithmetic is full-precision signed; IN_W+3 bits cannot overflow for 5 operands; no saturation is applied.
REQ-027 acc_ready = 0 while rst or flush is high, and in CAP.
REQ-028 acc_ready = 0 when the next accept would be a trigger and either (sum_valid=1 && sum_ready=0) or the FSM is in ADD; otherwise acc_ready = 1. A pending sum is never overwritten.
REQ-029 sum_valid clears on consume unless a new sum is registered in the same cycle, in which case it stays 1 with the new sum_out.
REQ-030 sum_out holds its value while sum_valid=1 && sum_ready=0.
REQ-031 Boundary, acc_valid=0 in any state: counters hold and the FSM proceeds unaffected.
REQ-032 Boundary, flush: fill_cnt and phase_cnt go to 0, the FSM goes to RUN, sum_valid goes to 0, and any in-flight partials are discarded; sum_out keeps its last value.
REQ-033 Boundary, flush coincident with acc_valid: the sample is not accepted.
REQ-034 Boundary, DECIM=1: a trigger fires on every accept after fill, subject to the backpressure in REQ-027 and REQ-028.

Reset
REQ-035 While rst=1: sum_out=0, sum_valid=0, acc_ready=0, sr_en=1, sr_data_ready=0, sr_rst=1, fill_cnt=0, phase_cnt=0, state=RUN.
REQ-036 Reset mid-operation (CAP, ADD, or sum pending) aborts everything to the REQ-035 values on the next edge.
REQ-037 Controller and shift register leave reset on the same edge.

Verification
REQ-038 Fill: after reset, accept samples 1,2,3,4,5 back-to-back with sum_ready=1 -> sum_valid=1 exactly 3 cycles after the 5th accept, sum_out=15; sr_data_ready pulses 5 times.
REQ-039 Decimation: with DECIM=5, continue accepting 6..10 -> second sum_out=40 (6+7+8+9+10); no sum is emitted between the two windows.
REQ-040 Backpressure: hold sum_ready=0 after the first sum and offer samples 6..10 -> acc_ready=0 when sample 10 is offered, sum_out stays 15; raise sum_ready -> 15 is consumed, 10 is accepted, and the next sum_out=40.
REQ-041 Negative extremes: five samples of -2^36 (IN_W=37) -> sum_out = -5*2^36 with correct sign and no wrap.
REQ-042 Flush in ADD: flush one cycle after CAP -> sum_valid stays 0, sr_rst=1 for that cycle; the next fill of 1..5 -> sum_out=15.
REQ-043 Reset mid-hold: rst while sum_valid=1 && sum_ready=0 -> all outputs match REQ-035 on the next edge.
